// File: rtl/csr_mon_pkg.sv
// rtl/csr_mon_pkg.sv - shared constants for the tohost monitor; entry width depends on CSR_MON_STAMP_EN
package csr_mon_pkg;

    // CSR address of tohost in the machine-mode CSR map.
    localparam logic [11:0] TOHOST_ADDR_DEF = 12'h51E;

    // Monitor FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width of the data field of one FIFO entry.
    localparam int DATA_W = 32;

`ifdef CSR_MON_STAMP_EN
    // Each entry carries {cycle_stamp, data}.
    localparam int ENTRY_W = 64;
`else
    localparam int ENTRY_W = 32;
`endif

    // A tohost write with bit 0 set ends the test; the remaining bits
    // hold the failure code, so a value of exactly 1 means pass.
    function automatic logic is_terminating(input logic [31:0] value);
        return value[0];
    endfunction

    function automatic logic is_pass(input logic [31:0] value);
        return value == 32'd1;
    endfunction

endpackage

// File: rtl/csr_mon_fifo.sv
// rtl/csr_mon_fifo.sv - synchronous FIFO with push/pop/full/empty/count
module csr_mon_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;
    logic             push_ok;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // lands when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/csr_tohost_monitor.sv
// rtl/csr_tohost_monitor.sv - tohost CSR capture, FIFO drain to host, end-of-test decode; CSR_MON_STAMP_EN adds host_stamp
module csr_tohost_monitor
    import csr_mon_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [11:0] TOHOST_ADDR = TOHOST_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_data,
    output logic        host_valid,
    input  logic        host_ready,
    output logic [31:0] host_data,
`ifdef CSR_MON_STAMP_EN
    output logic [31:0] host_stamp,
`endif
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]         state;
    logic               accept;
    logic               terminate;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Only nonzero tohost writes while running count; zero is the idle value of tohost.
    assign accept    = (state == ST_RUN) & csr_valid & (csr_addr == TOHOST_ADDR) & (csr_data != '0);
    assign terminate = accept & is_terminating(csr_data);
    assign pop       = host_valid & host_ready;

    // Monitor lifecycle: armed by the host, closed by the terminating write, reopened only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (enable)    state <= ST_RUN;
                ST_RUN:  if (terminate) state <= ST_DONE;
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // End-of-test result and sticky overflow; a write is lost only when full with no pop to make room.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            overflow  <= 1'b0;
        end else begin
            if (terminate) begin
                done <= 1'b1;
                pass <= is_pass(csr_data);
                if (!is_pass(csr_data)) begin
                    fail_code <= csr_data[31:1];
                end
            end
            if (accept && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef CSR_MON_STAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running timestamp, frozen while idle so stamps are relative to arming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (state != ST_IDLE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign push_entry = {cycle_cnt, csr_data};
    assign host_stamp = fifo_empty ? 32'd0 : head_entry[63:32];
`else
    assign push_entry = csr_data;
`endif

    csr_mon_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head presentation comes straight from registered FIFO state, so it holds while the host stalls.
    assign host_valid = (fifo_count != '0);
    assign host_data  = fifo_empty ? 32'd0 : head_entry[31:0];

endmodule

// File: tb/tb_csr_tohost_monitor.sv
// tb/tb_csr_tohost_monitor.sv - self-checking bench for csr_tohost_monitor with queue reference model
module tb_csr_tohost_monitor;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_data = '0;
    logic        host_valid;
    logic        host_ready = 1'b0;
    logic [31:0] host_data;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        overflow;
`ifdef CSR_MON_STAMP_EN
    logic [31:0] host_stamp;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 running, 2 finished
    int          m_state;
    logic [63:0] mq[$];
    logic        m_done;
    logic        m_pass;
    logic [30:0] m_fc;
    logic        m_ovf;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    csr_tohost_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .csr_valid  (csr_valid),
        .csr_addr   (csr_addr),
        .csr_data   (csr_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
`ifdef CSR_MON_STAMP_EN
        .host_stamp (host_stamp),
`endif
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .overflow   (overflow)
    );

    task automatic model_reset();
        m_state = 0;
        mq.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
        m_fc   = '0;
        m_ovf  = 1'b0;
        m_cnt  = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample at the next negedge.
    task automatic step(input logic en, input logic v, input logic [11:0] a, input logic [31:0] d, input logic rdy);
        bit          do_pop;
        bit          acc;
        int          pre;
        logic [63:0] tmp;
        enable     = en;
        csr_valid  = v;
        csr_addr   = a;
        csr_data   = d;
        host_ready = rdy;
        if (!rst_n) begin
            model_reset();
        end else begin
            pre    = mq.size();
            do_pop = (pre > 0) && rdy;
            acc    = (m_state == 1) && v && (a == 12'h51E) && (d != 0);
            if (do_pop) tmp = mq.pop_front();
            if (acc) begin
                if (pre < DEPTH || do_pop) mq.push_back({m_cnt, d});
                else m_ovf = 1'b1;
                if (d[0]) begin
                    m_done = 1'b1;
                    m_pass = (d == 32'd1);
                    if (d != 32'd1) m_fc = d[31:1];
                end
            end
            if (m_state != 0) m_cnt = m_cnt + 1;
            if (m_state == 0 && en) m_state = 1;
            else if (acc && d[0]) m_state = 2;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 12'h0, 32'h0, 0);
        rst_n = 1'b1;
    endtask

    task automatic tohost(input logic [31:0] d, input logic rdy);
        step(0, 1, 12'h51E, d, rdy);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (host_valid !== 1'b0) begin n_fail++; $display("FAIL reset_host_valid got %0b want 0", host_valid); end
        n_checks++; if (host_data !== 32'h0) begin n_fail++; $display("FAIL reset_host_data got %h want 0", host_data); end
        n_checks++; if ({done, pass, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {done, pass, overflow}); end
        n_checks++; if (fail_code !== 31'h0) begin n_fail++; $display("FAIL reset_fail_code got %h want 0", fail_code); end
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 0, 12'h0, 32'h0, 0);
        tohost(32'h10, 0);
        n_checks++; if (host_valid !== 1'b1 || host_data !== 32'h10) begin n_fail++; $display("FAIL basic_push got v=%0b d=%h want v=1 d=10", host_valid, host_data); end
        step(0, 0, 12'h0, 32'h0, 0);
        n_checks++; if (host_valid !== 1'b1 || host_data !== 32'h10) begin n_fail++; $display("FAIL basic_hold got v=%0b d=%h want v=1 d=10", host_valid, host_data); end
        step(0, 0, 12'h0, 32'h0, 1);
        n_checks++; if (host_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got v=%0b want 0", host_valid); end
    endtask

    task automatic test_ignored();
        step(0, 1, 12'h300, 32'h5, 0);
        tohost(32'h0, 0);
        n_checks++; if (host_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ignored_writes got v=%0b done=%0b want 0 0", host_valid, done); end
    endtask

    task automatic test_pass();
        tohost(32'h1, 0);
        n_checks++; if (done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("FAIL pass_flags got done=%0b pass=%0b want 1 1", done, pass); end
        n_checks++; if (host_valid !== 1'b1 || host_data !== 32'h1) begin n_fail++; $display("FAIL pass_entry got v=%0b d=%h want v=1 d=1", host_valid, host_data); end
        tohost(32'h20, 1);
        step(1, 1, 12'h51E, 32'h4, 1);
        n_checks++; if (host_valid !== 1'b0) begin n_fail++; $display("FAIL pass_after_done got v=%0b want 0", host_valid); end
        n_checks++; if (done !== 1'b1 || pass !== 1'b1 || fail_code !== 31'h0) begin n_fail++; $display("FAIL pass_sticky got done=%0b pass=%0b fc=%h want 1 1 0", done, pass, fail_code); end
    endtask

    task automatic test_fail();
        do_reset();
        step(1, 0, 12'h0, 32'h0, 0);
        tohost(32'h7, 0);
        n_checks++; if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 31'd3) begin n_fail++; $display("FAIL fail_decode got done=%0b pass=%0b fc=%0d want 1 0 3", done, pass, fail_code); end
        n_checks++; if (host_data !== 32'h7) begin n_fail++; $display("FAIL fail_entry got %h want 7", host_data); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_a [4];
        logic [31:0] exp_b [4];
        exp_a = '{32'h2, 32'h4, 32'h6, 32'h8};
        exp_b = '{32'h4, 32'h6, 32'h8, 32'hC};
        do_reset();
        step(1, 0, 12'h0, 32'h0, 0);
        for (int i = 1; i <= 5; i++) tohost(32'(2 * i), 0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %0b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (host_valid !== 1'b1 || host_data !== exp_a[i]) begin n_fail++; $display("FAIL overflow_order[%0d] got v=%0b d=%h want v=1 d=%h", i, host_valid, host_data, exp_a[i]); end
            step(0, 0, 12'h0, 32'h0, 1);
        end
        n_checks++; if (host_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_drained got v=%0b want 0", host_valid); end
        do_reset();
        step(1, 0, 12'h0, 32'h0, 0);
        for (int i = 1; i <= 4; i++) tohost(32'(2 * i), 0);
        tohost(32'hC, 1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_ovf got %0b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (host_valid !== 1'b1 || host_data !== exp_b[i]) begin n_fail++; $display("FAIL full_push_pop_order[%0d] got v=%0b d=%h want v=1 d=%h", i, host_valid, host_data, exp_b[i]); end
            step(0, 0, 12'h0, 32'h0, 1);
        end
        n_checks++; if (host_valid !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_drained got v=%0b want 0", host_valid); end
    endtask

    task automatic test_reset_mid();
`ifdef CSR_MON_STAMP_EN
        logic [31:0] last;
`endif
        do_reset();
        step(1, 0, 12'h0, 32'h0, 0);
`ifdef CSR_MON_STAMP_EN
        tohost(32'h2, 0);
        step(0, 0, 12'h0, 32'h0, 0);
        tohost(32'h4, 0);
        tohost(32'h6, 0);
        last = 32'h0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (host_stamp !== mq[0][63:32] || (i > 0 && host_stamp <= last)) begin n_fail++; $display("FAIL stamp_increase[%0d] got %0d want %0d (prev %0d)", i, host_stamp, mq[0][63:32], last); end
            last = host_stamp;
            step(0, 0, 12'h0, 32'h0, 1);
        end
`endif
        tohost(32'h2, 0);
        tohost(32'h4, 0);
        tohost(32'h8, 0);
        tohost(32'h3, 0);
        do_reset();
        n_checks++; if (host_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_mid got v=%0b done=%0b ovf=%0b want 0 0 0", host_valid, done, overflow); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [11:0] a;
        logic        exp_v;
        int          sel;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            sel = int'($urandom_range(0, 15));
            case (sel)
                0:       d = 32'h0;
                1:       d = 32'h1;
                2:       d = $urandom | 32'h1;
                default: d = $urandom & 32'hFFFF_FFFE;
            endcase
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h51E;
            if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 3) != 0 && c % 40 > 12);
            rst_n = 1'b1;
            exp_v = (mq.size() > 0);
            n_checks++; if (host_valid !== exp_v) begin n_fail++; $display("FAIL rand_host_valid cyc %0d got %0b want %0b", c, host_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (host_data !== mq[0][31:0]) begin n_fail++; $display("FAIL rand_host_data cyc %0d got %h want %h", c, host_data, mq[0][31:0]); end
`ifdef CSR_MON_STAMP_EN
                n_checks++; if (host_stamp !== mq[0][63:32]) begin n_fail++; $display("FAIL rand_host_stamp cyc %0d got %0d want %0d", c, host_stamp, mq[0][63:32]); end
`endif
            end
            n_checks++; if ({done, pass, overflow} !== {m_done, m_pass, m_ovf}) begin n_fail++; $display("FAIL rand_flags cyc %0d got %b want %b", c, {done, pass, overflow}, {m_done, m_pass, m_ovf}); end
            n_checks++; if (fail_code !== m_fc) begin n_fail++; $display("FAIL rand_fail_code cyc %0d got %h want %h", c, fail_code, m_fc); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_ignored();
        test_pass();
        test_fail();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
